// File: rtl/sw_cond_pkg.sv
// Shared types and defaults for the push-button conditioner.
//   sw_state_t : per-channel debounce / hold state
//   cnt_w()    : width needed to hold a counter value 0..n
package sw_cond_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRESS_DB,
    HELD,
    LONG,
    REL_DB
  } sw_state_t;

  localparam int DEF_NUM_SW     = 3;
  localparam int DEF_TICK_DIV   = 50000;
  localparam int DEF_DB_TICKS   = 20;
  localparam int DEF_LONG_TICKS = 1000;
  localparam int DEF_RPT_TICKS  = 200;
  localparam int DEF_ACTIVE_LOW = 1;

  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sw_chan_fsm.sv
// One switch channel: 2-FF synchroniser, debounce/hold FSM, tick counters.
//   clk, rst_n : clock, synchronous active-low reset
//   tick       : shared debounce tick, FSM advances only when high
//   pad        : raw asynchronous pad
//   lvl        : debounced level (1 = pressed)
//   press/rel/long_ev/rpt : one-clk event pulses, registered
module sw_chan_fsm
  import sw_cond_pkg::*;
#(
  parameter int DB_TICKS   = DEF_DB_TICKS,
  parameter int LONG_TICKS = DEF_LONG_TICKS,
  parameter int RPT_TICKS  = DEF_RPT_TICKS,
  parameter int ACTIVE_LOW = DEF_ACTIVE_LOW
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic pad,
  output logic lvl,
  output logic press,
  output logic rel,
  output logic long_ev,
  output logic rpt
);

  localparam int HW = cnt_w((LONG_TICKS > RPT_TICKS) ? LONG_TICKS : RPT_TICKS);
  localparam int DW = cnt_w(DB_TICKS);
  localparam logic [HW-1:0] LONG_M1 = HW'(LONG_TICKS - 1);
  localparam logic [HW-1:0] RPT_M1  = HW'(RPT_TICKS - 1);
  localparam logic [DW-1:0] DB_M1   = DW'(DB_TICKS - 1);
  // Synchroniser resets to the released pad level so reset never looks like a press.
  localparam logic PAD_IDLE = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  logic            sync1, sync2;
  logic            p;
  sw_state_t       state, ret;
  sw_state_t       hs;
  logic [HW-1:0]   hcnt, term_m1, hcnt_sat;
  logic [DW-1:0]   dcnt;
  logic            hit;

  assign p = (ACTIVE_LOW != 0) ? ~sync2 : sync2;

  // Hold phase that owns the counter; during release debounce that is the saved state.
  assign hs       = (state == REL_DB) ? ret : state;
  assign term_m1  = (hs == LONG) ? RPT_M1 : LONG_M1;
  assign hit      = (hcnt >= term_m1);
  // The hold count keeps running through a release bounce but parks one short of its
  // terminal value, so a deferred long/rpt fires on the first clean held tick.
  assign hcnt_sat = hit ? term_m1 : hcnt + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1   <= PAD_IDLE;
      sync2   <= PAD_IDLE;
      state   <= IDLE;
      ret     <= HELD;
      hcnt    <= '0;
      dcnt    <= '0;
      lvl     <= 1'b0;
      press   <= 1'b0;
      rel     <= 1'b0;
      long_ev <= 1'b0;
      rpt     <= 1'b0;
    end else begin
      sync1   <= pad;
      sync2   <= sync1;
      press   <= 1'b0;
      rel     <= 1'b0;
      long_ev <= 1'b0;
      rpt     <= 1'b0;
      if (tick) begin
        case (state)
          IDLE: if (p) begin
            if (DB_TICKS <= 1) begin
              state <= HELD;
              hcnt  <= '0;
              lvl   <= 1'b1;
              press <= 1'b1;
            end else begin
              state <= PRESS_DB;
              dcnt  <= DW'(1);
            end
          end
          PRESS_DB: begin
            if (!p) state <= IDLE;
            else if (dcnt >= DB_M1) begin
              state <= HELD;
              hcnt  <= '0;
              lvl   <= 1'b1;
              press <= 1'b1;
            end else dcnt <= dcnt + 1'b1;
          end
          HELD, LONG: begin
            if (!p) begin
              hcnt <= hcnt_sat;
              if (DB_TICKS <= 1) begin
                state <= IDLE;
                lvl   <= 1'b0;
                rel   <= 1'b1;
              end else begin
                ret   <= state;
                state <= REL_DB;
                dcnt  <= DW'(1);
              end
            end else if (hit) begin
              state <= LONG;
              hcnt  <= '0;
              if (state == HELD) long_ev <= 1'b1;
              else               rpt     <= 1'b1;
            end else hcnt <= hcnt + 1'b1;
          end
          REL_DB: begin
            if (p) begin
              state <= ret;
              hcnt  <= hcnt_sat;
            end else if (dcnt >= DB_M1) begin
              state <= IDLE;
              lvl   <= 1'b0;
              rel   <= 1'b1;
            end else begin
              dcnt <= dcnt + 1'b1;
              hcnt <= hcnt_sat;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/sw_conditioner.sv
// Push-button front end: shared 1 ms prescaler plus NUM_SW independent channels.
//   clk, rst_n : 50 MHz clock, synchronous active-low reset
//   i_sw       : raw pads
//   o_sw_lvl   : debounced level, 1 = pressed
//   o_sw_press / o_sw_rel / o_sw_long / o_sw_rpt : one-clk event pulses
module sw_conditioner
  import sw_cond_pkg::*;
#(
  parameter int NUM_SW     = DEF_NUM_SW,
  parameter int TICK_DIV   = DEF_TICK_DIV,
  parameter int DB_TICKS   = DEF_DB_TICKS,
  parameter int LONG_TICKS = DEF_LONG_TICKS,
  parameter int RPT_TICKS  = DEF_RPT_TICKS,
  parameter int ACTIVE_LOW = DEF_ACTIVE_LOW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_SW-1:0] i_sw,
  output logic [NUM_SW-1:0] o_sw_lvl,
  output logic [NUM_SW-1:0] o_sw_press,
  output logic [NUM_SW-1:0] o_sw_rel,
  output logic [NUM_SW-1:0] o_sw_long,
  output logic [NUM_SW-1:0] o_sw_rpt
);

  localparam int PW = cnt_w(TICK_DIV);
  localparam logic [PW-1:0] TICK_M1 = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc;
  logic          tick;

  assign tick = (presc == TICK_M1);

  always_ff @(posedge clk) begin
    if (!rst_n)    presc <= '0;
    else if (tick) presc <= '0;
    else           presc <= presc + 1'b1;
  end

  for (genvar gi = 0; gi < NUM_SW; gi++) begin : g_chan
    sw_chan_fsm #(
      .DB_TICKS   (DB_TICKS),
      .LONG_TICKS (LONG_TICKS),
      .RPT_TICKS  (RPT_TICKS),
      .ACTIVE_LOW (ACTIVE_LOW)
    ) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .tick    (tick),
      .pad     (i_sw[gi]),
      .lvl     (o_sw_lvl[gi]),
      .press   (o_sw_press[gi]),
      .rel     (o_sw_rel[gi]),
      .long_ev (o_sw_long[gi]),
      .rpt     (o_sw_rpt[gi])
    );
  end

endmodule

// File: tb/tb_sw_conditioner.sv
// Bench for sw_conditioner with short timing: directed scenarios plus random pad
// activity, checked every cycle against an event-level reference model.
module tb_sw_conditioner;

  localparam int NSW  = 3;
  localparam int TDIV = 4;
  localparam int DB   = 3;
  localparam int LNG  = 10;
  localparam int RPT  = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [NSW-1:0] i_sw = '0;
  logic [NSW-1:0] o_sw_lvl, o_sw_press, o_sw_rel, o_sw_long, o_sw_rpt;

  sw_conditioner #(
    .NUM_SW(NSW), .TICK_DIV(TDIV), .DB_TICKS(DB),
    .LONG_TICKS(LNG), .RPT_TICKS(RPT), .ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_sw(i_sw),
    .o_sw_lvl(o_sw_lvl), .o_sw_press(o_sw_press), .o_sw_rel(o_sw_rel),
    .o_sw_long(o_sw_long), .o_sw_rpt(o_sw_rpt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Debounce is a run of disagreeing ticks; hold events fire when the time since
  // press/long/rpt reaches its period on a tick where the switch was, and still is,
  // cleanly held (no release run in progress).
  logic [NSW-1:0] m_s1, m_s2;
  logic [NSW-1:0] e_lvl, e_press, e_rel, e_long, e_rpt;
  int  run [NSW];
  int  since [NSW];
  bit  long_done [NSW];
  int  clk_cnt;
  bit  started = 0;

  initial forever begin
    @(posedge clk);
    started = 1;
    e_press = '0; e_rel = '0; e_long = '0; e_rpt = '0;
    if (!rst_n) begin
      m_s1 = '1; m_s2 = '1; e_lvl = '0; clk_cnt = 0;
      for (int c = 0; c < NSW; c++) begin
        run[c] = 0; since[c] = 0; long_done[c] = 0;
      end
    end else begin
      bit tk;
      logic [NSW-1:0] pv;
      pv = ~m_s2;
      m_s2 = m_s1;
      m_s1 = i_sw;
      tk = ((clk_cnt % TDIV) == TDIV - 1);
      clk_cnt++;
      if (tk) begin
        for (int c = 0; c < NSW; c++) begin
          if (!e_lvl[c]) begin
            run[c] = pv[c] ? run[c] + 1 : 0;
            if (run[c] == DB) begin
              e_lvl[c] = 1'b1; e_press[c] = 1'b1;
              run[c] = 0; since[c] = 0; long_done[c] = 0;
            end
          end else begin
            bit ok;
            since[c]++;
            ok = (run[c] == 0) && pv[c];
            run[c] = pv[c] ? 0 : run[c] + 1;
            if (run[c] == DB) begin
              e_lvl[c] = 1'b0; e_rel[c] = 1'b1; run[c] = 0;
            end else if (ok && since[c] >= (long_done[c] ? RPT : LNG)) begin
              if (long_done[c]) e_rpt[c] = 1'b1;
              else              e_long[c] = 1'b1;
              long_done[c] = 1; since[c] = 0;
            end
          end
        end
      end
    end
  end

  // ---------------- per-cycle checker and pulse tallies ----------------
  int n_press [NSW];
  int n_rel   [NSW];
  int n_long  [NSW];
  int n_rpt   [NSW];
  int t_press [NSW];
  int t_long  [NSW];
  int cyc = 0;

  initial forever begin
    @(negedge clk);
    cyc++;
    if (started) begin
      chk("lvl",   o_sw_lvl,   e_lvl);
      chk("press", o_sw_press, e_press);
      chk("rel",   o_sw_rel,   e_rel);
      chk("long",  o_sw_long,  e_long);
      chk("rpt",   o_sw_rpt,   e_rpt);
      for (int c = 0; c < NSW; c++) begin
        if (o_sw_press[c] === 1'b1) begin n_press[c]++; t_press[c] = cyc; end
        if (o_sw_rel[c]   === 1'b1) n_rel[c]++;
        if (o_sw_long[c]  === 1'b1) begin n_long[c]++; t_long[c] = cyc; end
        if (o_sw_rpt[c]   === 1'b1) n_rpt[c]++;
      end
    end
  end

  task automatic clr_cnt();
    for (int c = 0; c < NSW; c++) begin
      n_press[c] = 0; n_rel[c] = 0; n_long[c] = 0; n_rpt[c] = 0;
      t_press[c] = 0; t_long[c] = 0;
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    clr_cnt();
    // 1: reset with all pads pressed; press must land on the 3rd tick
    rst_n = 1'b0; i_sw = 3'b000;
    clks(5);
    rst_n = 1'b1; clr_cnt();
    clks(10);
    chk("rst_early_press", n_press[0], 0);
    clks(2);
    chk("rst_press0", n_press[0], 1);
    chk("rst_press_all", o_sw_lvl, 3'b111);
    i_sw = 3'b111;
    clks(10 * TDIV);
    chk("rst_rel2", n_rel[2], 1);

    // 2: 2-tick glitch on sw1
    clr_cnt();
    i_sw[1] = 1'b0; clks(2 * TDIV);
    i_sw[1] = 1'b1; clks(6 * TDIV);
    chk("glitch_press", n_press[1], 0);
    chk("glitch_lvl", o_sw_lvl[1], 0);

    // 3: clean 8-tick press on sw0
    clr_cnt();
    i_sw[0] = 1'b0; clks(8 * TDIV);
    chk("clean_lvl", o_sw_lvl[0], 1);
    i_sw[0] = 1'b1; clks(8 * TDIV);
    chk("clean_press", n_press[0], 1);
    chk("clean_rel", n_rel[0], 1);
    chk("clean_long", n_long[0], 0);

    // 4: 25-tick hold on sw2: long then three repeats
    clr_cnt();
    i_sw[2] = 1'b0; clks(25 * TDIV);
    i_sw[2] = 1'b1; clks(8 * TDIV);
    chk("long_press", n_press[2], 1);
    chk("long_long", n_long[2], 1);
    chk("long_dt", t_long[2] - t_press[2], LNG * TDIV);
    chk("long_rpt", n_rpt[2], 3);
    chk("long_rel", n_rel[2], 1);

    // 5: release bounce inside HELD on sw1
    clr_cnt();
    i_sw[1] = 1'b0; clks(6 * TDIV);
    i_sw[1] = 1'b1; clks(2 * TDIV);
    i_sw[1] = 1'b0; clks(12 * TDIV);
    chk("bounce_rel_mid", n_rel[1], 0);
    i_sw[1] = 1'b1; clks(8 * TDIV);
    chk("bounce_press", n_press[1], 1);
    chk("bounce_long", n_long[1], 1);
    chk("bounce_long_dt", t_long[1] - t_press[1], LNG * TDIV);
    chk("bounce_rel", n_rel[1], 1);

    // 6: reset while in LONG on sw2
    clr_cnt();
    i_sw[2] = 1'b0; clks(15 * TDIV);
    chk("rstmid_long", n_long[2], 1);
    rst_n = 1'b0; clks(1);
    chk("rstmid_lvl", o_sw_lvl, 3'b000);
    rst_n = 1'b1; i_sw[2] = 1'b1;
    clks(8 * TDIV);
    chk("rstmid_norel", n_rel[2], 0);

    // random pad activity with occasional reset
    for (int it = 0; it < 150; it++) begin
      i_sw = 3'($urandom);
      clks($urandom_range(1, 80));
      if ($urandom_range(0, 39) == 0) begin
        rst_n = 1'b0; clks(1); rst_n = 1'b1;
      end
    end
    i_sw = 3'b111;
    clks(10 * TDIV);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
